reject_sample_packer: RTL and testbench

//   Downstream stage of the rejection sampler core. Takes its sparse per-lane

---
 rtl/reject_sample_packer.sv | 150 +++++++++++++++
 tb/tb_reject_sample_packer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reject_sample_packer.sv
// Packs the accepted lanes of each sampler beat, in lane order, into a
// single-coefficient FIFO stream. One polynomial is N_COEFFS coefficients.
module reject_sample_packer #(
   parameter int LANES     = 4,
   parameter int CAND_BITS = 12,
   parameter int DEPTH     = 16,
   parameter int N_COEFFS  = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         sample_tvalid,
   input  logic [LANES-1:0]             acc_bus,
   input  logic [LANES*CAND_BITS-1:0]   sample_tdata,
   output logic [CAND_BITS-1:0]         coef_tdata,
   output logic                         coef_tvalid,
   input  logic                         coef_tready,
   output logic                         coef_tlast,
   output logic                         need_more,
   output logic                         almost_full,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow,
   output logic [$clog2(DEPTH):0]       fill_level
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam int CNT_W  = $clog2(N_COEFFS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [CAND_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [FILL_W-1:0]   fill_q;
   logic [CNT_W-1:0]    push_cnt_q;
   logic [CNT_W-1:0]    pop_cnt_q;
   logic                overflow_q;

   logic                push_en;
   logic                pop;
   logic                drop_space;
   logic [31:0]         n_acc;
   logic [31:0]         room_cnt;
   logic [31:0]         room_fifo;
   logic [31:0]         n_want;
   logic [31:0]         n_push;
   logic [31:0]         rank;
   logic [LANES-1:0]    wr_en;
   logic [PTR_W-1:0]    wr_idx [LANES];

   assign coef_tvalid = (fill_q != '0);
   assign pop         = coef_tvalid & coef_tready & ~start;
   assign coef_tlast  = coef_tvalid & (pop_cnt_q == CNT_W'(N_COEFFS - 1));
   assign coef_tdata  = coef_tvalid ? mem[rd_ptr_q] : '0;
   assign need_more   = (state_q == S_FILL);
   assign busy        = (state_q == S_FILL) || (state_q == S_DRAIN);
   assign done        = (state_q == S_DONE);
   assign overflow    = overflow_q;
   assign fill_level  = fill_q;
   assign almost_full = (32'(DEPTH) - 32'(fill_q)) < 32'(2 * LANES);

   // Space is judged on the occupancy at cycle start: a same-cycle pop frees
   // nothing for this beat. Lanes past the polynomial limit are normal surplus.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      n_acc      = '0;
      rank       = '0;
      wr_en      = '0;
      for (int i = 0; i < LANES; i++) begin
         n_acc = n_acc + 32'(acc_bus[i]);
      end
      room_cnt   = 32'(N_COEFFS) - 32'(push_cnt_q);
      room_fifo  = 32'(DEPTH) - 32'(fill_q);
      n_want     = (n_acc < room_cnt) ? n_acc : room_cnt;
      push_en    = (state_q == S_FILL) && sample_tvalid && !start;
      n_push     = push_en ? ((n_want < room_fifo) ? n_want : room_fifo) : '0;
      drop_space = push_en && (n_want > room_fifo);
      for (int i = 0; i < LANES; i++) begin
         wr_en[i]  = acc_bus[i] && (rank < n_push);
         wr_idx[i] = wr_ptr_q + PTR_W'(rank);
         rank      = rank + 32'(acc_bus[i]);
      end
   end

   // NOTE: FIFO storage has no reset; coef_tdata is masked to 0 while empty instead.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (wr_en[i]) begin
            mem[wr_idx[i]] <= sample_tdata[i*CAND_BITS +: CAND_BITS];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else if (start) begin
         state_q    <= S_FILL;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_q + PTR_W'(n_push);
         fill_q     <= fill_q + FILL_W'(n_push) - FILL_W'(pop);
         push_cnt_q <= push_cnt_q + CNT_W'(n_push);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop_cnt_q != CNT_W'(N_COEFFS)) begin
               pop_cnt_q <= pop_cnt_q + 1'b1;
            end
         end
         if (drop_space) begin
            overflow_q <= 1'b1;
         end
         case (state_q)
            S_FILL: begin
               if (32'(push_cnt_q) + n_push == 32'(N_COEFFS)) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && coef_tlast) begin
                  state_q <= S_DONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reject_sample_packer.sv
// Self-checking bench for reject_sample_packer: directed scenarios plus a
// randomized run against a queue-based model of the packing rules.
module tb_reject_sample_packer;

   localparam int LANES = 4;
   localparam int CB    = 12;
   localparam int DEPTH = 16;
   localparam int N     = 256;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic                  sample_tvalid = 1'b0;
   logic [LANES-1:0]      acc_bus = '0;
   logic [LANES*CB-1:0]   sample_tdata = '0;
   logic                  coef_tready = 1'b0;
   logic [CB-1:0]         coef_tdata;
   logic                  coef_tvalid;
   logic                  coef_tlast;
   logic                  need_more;
   logic                  almost_full;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [$clog2(DEPTH):0] fill_level;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reject_sample_packer #(
      .LANES(LANES), .CAND_BITS(CB), .DEPTH(DEPTH), .N_COEFFS(N)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_tvalid(sample_tvalid),
      .acc_bus(acc_bus), .sample_tdata(sample_tdata), .coef_tdata(coef_tdata),
      .coef_tvalid(coef_tvalid), .coef_tready(coef_tready), .coef_tlast(coef_tlast),
      .need_more(need_more), .almost_full(almost_full), .busy(busy), .done(done),
      .overflow(overflow), .fill_level(fill_level)
   );

   // Reference model: a queue of coefficients plus polynomial bookkeeping.
   logic [CB-1:0] exp_q[$];
   int  m_push  = 0;
   int  m_pop   = 0;
   bit  m_ovf   = 0;
   int  m_phase = 0;   // 0 idle, 1 fill, 2 drain, 3 done

   task automatic model_reset();
      exp_q.delete();
      m_push = 0; m_pop = 0; m_ovf = 0; m_phase = 0;
   endtask

   task automatic model_step();
      int  fill0;
      int  taken;
      if (!rst_n) return;
      if (start) begin
         model_reset();
         m_phase = 1;
         return;
      end
      fill0 = exp_q.size();
      if (fill0 > 0 && coef_tready) begin
         if (m_phase == 2 && m_pop == N - 1) m_phase = 3;
         exp_q.delete(0);
         m_pop++;
      end
      if (m_phase == 1 && sample_tvalid) begin
         taken = 0;
         for (int i = 0; i < LANES; i++) begin
            if (acc_bus[i]) begin
               if (m_push == N) begin
               end else if (fill0 + taken == DEPTH) begin
                  m_ovf = 1;
               end else begin
                  exp_q.push_back(sample_tdata[i*CB +: CB]);
                  taken++;
                  m_push++;
               end
            end
         end
         if (m_push == N) m_phase = 2;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; sample_tvalid = 0; acc_bus = '0; coef_tready = 0;
   endtask

   task automatic test_reset();
      logic [CB+11:0] obs;
      rst_n = 0;
      for (int c = 0; c < 4; c++) begin
         start = 1'($urandom); sample_tvalid = 1'($urandom); acc_bus = 4'($urandom);
         coef_tready = 1'($urandom); sample_tdata = 48'({$urandom, $urandom});
         tick();
         obs = {coef_tvalid, coef_tlast, need_more, busy, done, overflow, almost_full, fill_level, coef_tdata};
         total++;
         if (obs !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", obs);
         end
      end
      idle_inputs();
      rst_n = 1;
      model_reset();
      tick();
      start = 1; tick(); start = 0;
      sample_tvalid = 1; acc_bus = '0;
      for (int c = 0; c < 3; c++) begin
         sample_tdata = 48'({$urandom, $urandom});
         tick();
         total++;
         if (fill_level !== 5'd0) begin
            bad++; $display("FAIL zero_accept_fill: got %0d want 0", fill_level);
         end
      end
      acc_bus = 4'hF; tick();
      sample_tvalid = 0; acc_bus = '0;
      total++;
      if (fill_level !== 5'd4) begin
         bad++; $display("FAIL preload_fill: got %0d want 4", fill_level);
      end
      #2 rst_n = 0;
      #1;
      obs = {coef_tvalid, coef_tlast, need_more, busy, done, overflow, almost_full, fill_level, coef_tdata};
      total++;
      if (obs !== '0) begin
         bad++; $display("FAIL async_reset: got %h want 0", obs);
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      tick();
   endtask

   task automatic test_sparse();
      idle_inputs();
      start = 1; tick(); start = 0;
      sample_tvalid = 1; acc_bus = 4'b1010; coef_tready = 1;
      sample_tdata = {12'h444, 12'h333, 12'h222, 12'h111};
      tick();
      sample_tvalid = 0; acc_bus = '0;
      total++;
      if (fill_level !== 5'd2 || coef_tvalid !== 1'b1 || coef_tdata !== 12'h222) begin
         bad++; $display("FAIL sparse_first: got fill=%0d v=%b d=%h want fill=2 v=1 d=222", fill_level, coef_tvalid, coef_tdata);
      end
      tick();
      total++;
      if (fill_level !== 5'd1 || coef_tdata !== 12'h444) begin
         bad++; $display("FAIL sparse_second: got fill=%0d d=%h want fill=1 d=444", fill_level, coef_tdata);
      end
      tick();
      total++;
      if (fill_level !== 5'd0 || coef_tvalid !== 1'b0) begin
         bad++; $display("FAIL sparse_empty: got fill=%0d v=%b want 0 0", fill_level, coef_tvalid);
      end
      idle_inputs();
   endtask

   // The source honours almost_full, so no accepted lane is lost to space.
   task automatic test_full_poly();
      int beats = 0;
      int hs = 0;
      int tlast_err = 0;
      idle_inputs();
      coef_tready = 1;
      start = 1; tick(); start = 0;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         if (coef_tvalid) begin
            hs++;
            if (coef_tlast !== (hs == N)) tlast_err++;
         end
         sample_tvalid = need_more && !almost_full;
         acc_bus = 4'hF;
         sample_tdata = 48'({$urandom, $urandom});
         if (sample_tvalid) beats++;
         tick();
         if (sample_tvalid && beats == 64) begin
            total++;
            if (need_more !== 1'b0) begin
               bad++; $display("FAIL need_more_fall: got %b want 0", need_more);
            end
         end
      end
      idle_inputs();
      total++;
      if (hs != N || beats != 64) begin
         bad++; $display("FAIL handshakes: got hs=%0d beats=%0d want %0d 64", hs, beats, N);
      end
      total++;
      if (tlast_err != 0) begin
         bad++; $display("FAIL tlast_position: got %0d wrong cycles want 0", tlast_err);
      end
      total++;
      if (done !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL poly_done: got done=%b ovf=%b busy=%b want 1 0 0", done, overflow, busy);
      end
   endtask

   logic [CB-1:0] vals [20];

   task automatic load_beats(input int nb);
      for (int b = 0; b < nb; b++) begin
         for (int l = 0; l < LANES; l++) begin
            vals[b*LANES + l] = 12'($urandom);
            sample_tdata[l*CB +: CB] = vals[b*LANES + l];
         end
         sample_tvalid = 1; acc_bus = 4'hF;
         tick();
      end
      sample_tvalid = 0; acc_bus = '0;
   endtask

   task automatic test_overflow();
      idle_inputs();
      start = 1; tick(); start = 0;
      load_beats(5);
      total++;
      if (fill_level !== 5'd16 || overflow !== 1'b1 || almost_full !== 1'b1) begin
         bad++; $display("FAIL overflow_state: got fill=%0d ovf=%b af=%b want 16 1 1", fill_level, overflow, almost_full);
      end
      coef_tready = 1;
      for (int i = 0; i < 16; i++) begin
         total++;
         if (coef_tvalid !== 1'b1 || coef_tdata !== vals[i]) begin
            bad++; $display("FAIL drain_order[%0d]: got v=%b d=%h want v=1 d=%h", i, coef_tvalid, coef_tdata, vals[i]);
         end
         tick();
      end
      total++;
      if (coef_tvalid !== 1'b0) begin
         bad++; $display("FAIL drain_empty: got v=%b want 0", coef_tvalid);
      end
      idle_inputs();
   endtask

   task automatic test_full_pop();
      idle_inputs();
      start = 1; tick(); start = 0;
      load_beats(4);
      total++;
      if (fill_level !== 5'd16 || overflow !== 1'b0) begin
         bad++; $display("FAIL full_no_ovf: got fill=%0d ovf=%b want 16 0", fill_level, overflow);
      end
      coef_tready = 1; sample_tvalid = 1; acc_bus = 4'hF;
      sample_tdata = 48'({$urandom, $urandom});
      tick();
      idle_inputs();
      total++;
      if (fill_level !== 5'd15 || overflow !== 1'b1 || coef_tdata !== vals[1]) begin
         bad++; $display("FAIL full_pop_no_credit: got fill=%0d ovf=%b d=%h want 15 1 %h", fill_level, overflow, coef_tdata, vals[1]);
      end
   endtask

   task automatic test_restart();
      idle_inputs();
      start = 1; tick(); start = 0;
      load_beats(5);
      coef_tready = 1;
      for (int i = 0; i < 9; i++) tick();
      coef_tready = 0;
      total++;
      if (fill_level !== 5'd7 || overflow !== 1'b1) begin
         bad++; $display("FAIL restart_setup: got fill=%0d ovf=%b want 7 1", fill_level, overflow);
      end
      start = 1; sample_tvalid = 1; acc_bus = 4'hF; coef_tready = 1;
      tick();
      idle_inputs();
      total++;
      if (fill_level !== 5'd0 || coef_tvalid !== 1'b0 || overflow !== 1'b0 ||
          need_more !== 1'b1 || coef_tlast !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL restart_clear: got fill=%0d v=%b ovf=%b nm=%b tl=%b busy=%b want 0 0 0 1 0 1",
                         fill_level, coef_tvalid, overflow, need_more, coef_tlast, busy);
      end
   endtask

   task automatic test_random();
      logic [CB+6:0] exp_dp;
      logic [CB+6:0] got_dp;
      logic [4:0]    exp_st;
      logic [4:0]    got_st;
      int dp_err = 0;
      int st_err = 0;
      idle_inputs();
      start = 1; tick(); start = 0;
      for (int c = 0; c < 3000; c++) begin
         start = (m_phase == 3 && $urandom_range(3) == 0) || ($urandom_range(399) == 0);
         sample_tvalid = 1'($urandom);
         acc_bus = 4'($urandom);
         sample_tdata = 48'({$urandom, $urandom});
         coef_tready = ($urandom_range(3) != 0);
         tick();
         exp_dp = {exp_q.size() > 0, (exp_q.size() > 0) ? exp_q[0] : 12'h000,
                   5'(exp_q.size()), exp_q.size() > 0 && m_pop == N - 1};
         got_dp = {coef_tvalid, coef_tdata, fill_level, coef_tlast};
         exp_st = {m_phase == 1, m_phase == 1 || m_phase == 2, m_phase == 3, m_ovf,
                   (DEPTH - exp_q.size()) < 2 * LANES};
         got_st = {need_more, busy, done, overflow, almost_full};
         if (got_dp !== exp_dp) begin
            dp_err++;
            if (dp_err <= 5) $display("FAIL rand_data c=%0d: got %h want %h", c, got_dp, exp_dp);
         end
         if (got_st !== exp_st) begin
            st_err++;
            if (st_err <= 5) $display("FAIL rand_status c=%0d: got %b want %b", c, got_st, exp_st);
         end
      end
      idle_inputs();
      total++;
      if (dp_err != 0) bad++;
      total++;
      if (st_err != 0) bad++;
   endtask

   initial begin
      test_reset();
      test_sparse();
      test_full_poly();
      test_overflow();
      test_full_pop();
      test_restart();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
